tqvp_pulse_generator: RTL and testbench

- Memory-mapped TinyQV peripheral that emits a programmed burst of pulses on uo_out[0]. It is the transmit-side counterpart of the edge-counter peripheral.
- Software loads a pulse count, a high width and a low width, then writes START.
- The block generates exactly COUNT pulses, decrementing COUNT on each pulse's trailing edge, then sets a sticky DONE flag.
- An edge counter configured for falling edges (non-inverted output) and looped back from uo_out[0] therefore counts exactly the programmed COUNT.

---
 rtl/tqvp_pulse_generator_if.sv | 9 +
 rtl/tqvp_pulse_generator.sv | 84 ++++++++
 tb/tb_tqvp_pulse_generator.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tqvp_pulse_generator_if.sv
// tqvp_pulse_generator_if: TinyQV peripheral register bus
interface tqvp_pulse_generator_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  modport master (output address, data_write, data_in, input data_out);
  modport slave  (input address, data_write, data_in, output data_out);
endinterface

// File: rtl/tqvp_pulse_generator.sv
// tqvp_pulse_generator: emits a programmed burst of COUNT pulses on uo_out[0]
module tqvp_pulse_generator (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   ui_in,
  output logic [7:0]                   uo_out,
  tqvp_pulse_generator_if.slave        bus
);
  localparam logic [3:0] ADDR_COUNT = 4'h0;
  localparam logic [3:0] ADDR_HIGH  = 4'h1;
  localparam logic [3:0] ADDR_LOW   = 4'h2;
  localparam logic [3:0] ADDR_CTRL  = 4'h3;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state_q, state_d;
  logic [7:0] count_q, count_d, high_q, high_d, low_q, low_d, ph_q, ph_d;
  logic inv_q, inv_d, done_q, done_d;
  logic wr_idle, ctrl_wr, start_w, stop_w, clr_w, busy, unused_ui;
  logic [7:0] hw, lw;
  assign unused_ui = ^ui_in;
  assign busy    = state_q != IDLE;
  assign wr_idle = bus.data_write && !busy;
  assign ctrl_wr = bus.data_write && bus.address == ADDR_CTRL;
  assign start_w = ctrl_wr && bus.data_in[0];
  assign stop_w  = ctrl_wr && bus.data_in[2];
  assign clr_w   = ctrl_wr && bus.data_in[3];
  assign hw = (high_q == 8'd0) ? 8'd1 : high_q;
  assign lw = (low_q == 8'd0) ? 8'd1 : low_q;
  assign high_d = (wr_idle && bus.address == ADDR_HIGH) ? bus.data_in : high_q;
  assign low_d  = (wr_idle && bus.address == ADDR_LOW) ? bus.data_in : low_q;
  assign inv_d  = (wr_idle && bus.address == ADDR_CTRL) ? bus.data_in[1] : inv_q;
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    count_d = (wr_idle && bus.address == ADDR_COUNT) ? bus.data_in : count_q;
    done_d  = clr_w ? 1'b0 : done_q;
    if (state_q == IDLE && start_w && count_q != 8'd0) begin
      state_d = HIGH;
      ph_d    = hw;
      done_d  = 1'b0;
    end else if (state_q == HIGH) begin
      ph_d = ph_q - 8'd1;
      if (ph_q <= 8'd1) begin
        count_d = (count_q != 8'd0) ? count_q - 8'd1 : 8'd0;
        state_d = (count_q <= 8'd1) ? IDLE : LOW;
        ph_d    = (count_q <= 8'd1) ? 8'd0 : lw;
        done_d  = (count_q <= 8'd1) ? 1'b1 : done_d;
      end
    end else if (state_q == LOW) begin
      state_d = (ph_q <= 8'd1) ? HIGH : LOW;
      ph_d    = (ph_q <= 8'd1) ? hw : ph_q - 8'd1;
    end
    // STOP overrides everything; the interrupted pulse stays in COUNT
    if (stop_w) begin
      state_d = IDLE;
      ph_d    = 8'd0;
      count_d = count_q;
      done_d  = clr_w ? 1'b0 : done_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= 8'd0;
      count_q <= 8'd0;
      high_q  <= 8'd0;
      low_q   <= 8'd0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      count_q <= count_d;
      high_q  <= high_d;
      low_q   <= low_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end
  assign uo_out = {5'b0, done_q, busy, (state_q == HIGH) ^ inv_q};
  assign bus.data_out = (bus.address == ADDR_COUNT) ? count_q :
                        (bus.address == ADDR_HIGH)  ? high_q  :
                        (bus.address == ADDR_LOW)   ? low_q   :
                        (bus.address == ADDR_CTRL)  ? {5'b0, done_q, inv_q, busy} : 8'h00;
endmodule

// File: tb/tb_tqvp_pulse_generator.sv
// tb_tqvp_pulse_generator: scoreboard bench for the pulse generator peripheral
module tb_tqvp_pulse_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  tqvp_pulse_generator_if bus();
  tqvp_pulse_generator dut (.clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    int kind;
    logic [7:0] mask;
    logic [7:0] val;
    string name;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, vectors = 0, miscompares = 0, lb_cnt = 0, lb_base = 0, e = 0;
  logic lb_prev = 1'b0;
  // reference falling-edge counter looped back from the pulse pin
  always @(posedge clk) begin
    cyc <= cyc + 1;
    lb_prev <= uo_out[0];
    if (lb_prev && !uo_out[0]) lb_cnt <= lb_cnt + 1;
  end
  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: check at cycle %0d never sampled", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        act = (sb[i].kind == 0) ? uo_out : (sb[i].kind == 1) ? bus.data_out : 8'(lb_cnt - lb_base);
        vectors++;
        if ((act & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
          miscompares++;
          $display("FAIL %s: cycle %0d got %h expected %h (mask %h)", sb[i].name, cyc, act, sb[i].val, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int c, input int k, input logic [7:0] m, input logic [7:0] v, input string nm);
    exp_t x;
    x.cyc = c;
    x.kind = k;
    x.mask = m;
    x.val = v;
    x.name = nm;
    sb.push_back(x);
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.address = a;
    bus.data_in = d;
    bus.data_write = 1'b1;
    tick(1);
    bus.data_write = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [7:0] v, input string nm);
    bus.address = a;
    push(cyc, 1, 8'hff, v, nm);
    tick(1);
  endtask
  task automatic pat(input int s, input logic [15:0] p, input int n, input string nm);
    for (int k = 0; k < n; k++) push(s + k, 0, 8'h03, {6'b0, 1'b1, p[n-1-k]}, nm);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.address = 4'h0;
    bus.data_in = 8'h00;
    bus.data_write = 1'b0;
    tick(2);
    push(cyc, 0, 8'hff, 8'h00, "reset_uo");
    tick(1);
    rst = 1'b0;
    tick(1);
    rd(4'h0, 8'h00, "rst_count");
    rd(4'h1, 8'h00, "rst_high");
    rd(4'h2, 8'h00, "rst_low");
    rd(4'h3, 8'h00, "rst_ctrl");
    rd(4'h7, 8'h00, "unmapped");
    wr(4'h0, 8'd3); wr(4'h1, 8'd2); wr(4'h2, 8'd1); wr(4'h3, 8'h01);
    e = cyc;
    pat(e, 16'b11011011, 8, "basic_pin");
    push(e + 8, 0, 8'hff, 8'h04, "basic_end_uo");
    tick(8);
    rd(4'h3, 8'h04, "basic_ctrl");
    rd(4'h0, 8'h00, "basic_count");
    wr(4'h3, 8'h02);
    push(cyc, 0, 8'h01, 8'h01, "inv_idle_pin");
    wr(4'h1, 8'd0); wr(4'h2, 8'd0); wr(4'h0, 8'd2); wr(4'h3, 8'h03);
    e = cyc;
    pat(e, 16'b010, 3, "inv_pin");
    push(e + 3, 0, 8'hff, 8'h05, "inv_end_uo");
    tick(3);
    rd(4'h3, 8'h06, "inv_ctrl");
    wr(4'h3, 8'h03);
    rd(4'h3, 8'h06, "start_cnt0_done1");
    wr(4'h3, 8'h08);
    rd(4'h3, 8'h00, "clr_and_uninvert");
    wr(4'h3, 8'h01);
    push(cyc, 0, 8'hff, 8'h00, "start_cnt0_uo");
    rd(4'h3, 8'h00, "start_cnt0_done0");
    wr(4'h0, 8'd2); wr(4'h1, 8'd3); wr(4'h2, 8'd2); wr(4'h3, 8'h01);
    e = cyc;
    pat(e, 16'b11100111, 8, "busy_pin");
    wr(4'h0, 8'd9);
    wr(4'h1, 8'd1);
    rd(4'h0, 8'd2, "busy_count");
    rd(4'h1, 8'd3, "busy_high");
    tick(3);
    wr(4'h3, 8'h08);
    rd(4'h3, 8'h04, "clr_vs_done");
    wr(4'h0, 8'd5); wr(4'h1, 8'd4); wr(4'h2, 8'd4); wr(4'h3, 8'h01);
    e = cyc;
    pat(e, 16'b1111000011, 10, "stop_pin");
    push(e + 10, 0, 8'hff, 8'h00, "stop_uo");
    push(e + 11, 0, 8'hff, 8'h00, "stop_uo_hold");
    tick(9);
    wr(4'h3, 8'h05);
    rd(4'h0, 8'd4, "stop_count");
    rd(4'h3, 8'h00, "stop_ctrl");
    wr(4'h0, 8'd200); wr(4'h1, 8'd1); wr(4'h2, 8'd1);
    lb_base = lb_cnt;
    wr(4'h3, 8'h01);
    e = cyc;
    push(e + 401, 2, 8'hff, 8'hc8, "loop_cnt");
    tick(401);
    rd(4'h0, 8'h00, "loop_count");
    rd(4'h3, 8'h04, "loop_ctrl");
    wr(4'h0, 8'd5); wr(4'h1, 8'd3); wr(4'h3, 8'h01);
    tick(1);
    rst = 1'b1;
    push(cyc, 0, 8'hff, 8'h00, "async_rst_uo");
    tick(1);
    rst = 1'b0;
    rd(4'h0, 8'h00, "mid_rst_count");
    rd(4'h1, 8'h00, "mid_rst_high");
    rd(4'h2, 8'h00, "mid_rst_low");
    rd(4'h3, 8'h00, "mid_rst_ctrl");
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending checks expected 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
